clock_ctrl: RTL and testbench
=============================

# clock_ctrl

Timekeeping and time-set controller that produces the 12-bit `time_bus` consumed by the 4-digit seven-segment display driver. Divides the system clock to a 1 Hz tick and keeps 12-hour time as hour (binary 1–12), tens-of-minutes and minutes (BCD) with an AM/PM flag. A debounced two-button interface steps through RUN, SET_HR and SET_MIN modes. Sits between the board buttons and the display driver; the display driver needs no changes.

## Interface

**Parameters**

- `sys_freq`, default 100000000: clk cycles per second tick.
- `db_cycles`, default 1000000: consecutive stable synchronized samples required to accept a button level.

**Ports**

- `clk` in 1: system clock. All logic is on the rising edge.
- `btnU` in 1: reset, synchronous, active-high.
- `btnC` in 1: raw mode button, asynchronous to clk.
- `btnR` in 1: raw increment button, asynchronous to clk.
- `time_bus` out 12: registered `{hour[3:0], tenmin[3:0], min[3:0]}`.
- `pm` out 1: 1 = PM.
- `set_mode` out 2: 00 RUN, 01 SET_HR, 10 SET_MIN.
- `sec_tick` out 1: one-cycle pulse on each 1 Hz tick, including ticks that occur in set modes.

## Operation

**Reset**
- On `btnU`=1: `hour`=12, `tenmin`=0, `min`=0, `sec`=0, `pm`=0, `set_mode`=RUN.
- Tick counter = 0, `sec_tick`=0, debounce state cleared, accepted button levels = 0.
- Reset applied mid-operation (any mode, mid-debounce) takes effect on that edge with identical values.

**Button conditioning** (per button, independent)
- 2-flop synchronizer.
- Counter `db_cnt` counts consecutive synchronized samples that differ from the accepted level.
- When the count reaches `db_cycles`, the accepted level flips.
- Any sample equal to the accepted level clears `db_cnt`.
- A 0→1 flip of the accepted level produces a one-cycle pulse: `c_pulse` or `r_pulse`.
- Release produces no pulse.

**Tick generator**
- `tick_cnt` counts 0..`sys_freq`-1 and wraps.
- `sec_tick`=1 in the cycle `tick_cnt`==`sys_freq`-1.
- The counter is cleared, not wrapped, on the SET_MIN→RUN transition.

**Mode FSM**
- RUN --`c_pulse`--> SET_HR --`c_pulse`--> SET_MIN --`c_pulse`--> RUN.
- On entering RUN from SET_MIN: `sec`=0 and `tick_cnt`=0, so the first tick follows exactly `sys_freq` cycles later.

**RUN**
- On tick: `sec` counts 0..59.
- On tick with `sec`==59: `sec`=0 and minute advance.
- Minute advance:
  - `min` 0..9; at 9 → 0 with carry.
  - Carry: `tenmin` 0..5; `tenmin`=5 with carry → 0 and hour advance.
- Hour advance: 12→1; 11→12 toggles `pm`; otherwise +1.
- `r_pulse` is ignored in RUN.

**SET_HR**
- `r_pulse` performs one hour advance, including the `pm` toggle on 11→12.
- Ticks do not modify time, and `sec` holds.

**SET_MIN**
- `r_pulse` advances minutes 00..59 and wraps 59→00 with no carry into hour.
- Ticks are ignored.

**Simultaneous events**
- `c_pulse` and `r_pulse` in the same cycle: the mode change wins and `r_pulse` is dropped.
- Tick and `c_pulse` in the same cycle in RUN: the time advance and the transition to SET_HR both occur.
- Tick in the same cycle as the SET_MIN→RUN transition: the tick is discarded and the `sec`/counter clear applies.

**Arithmetic and range**
- `hour` is never 0 or greater than 12.
- `tenmin` is never greater than 5; `min` is never greater than 9.
- Field updates are BCD compare-and-reset, not binary add with correction.

## Timing

- `time_bus`, `pm` and `set_mode` are registered and update on the clk edge where the causing event is sampled.
- Tick to `time_bus` change: same edge; new value visible the cycle after `sec_tick`.
- Button latency, raw edge to pulse: 2 synchronizer cycles + `db_cycles` + 1 cycle. The field update appears one cycle after the pulse.
- A held button yields exactly one pulse. There is no auto-repeat.
- Glitches shorter than `db_cycles` samples produce no pulse.

## Test plan

Run all scenarios with `sys_freq`=10 and `db_cycles`=4.

1. **Reset values:** assert `btnU` for 1 cycle → `time_bus`=0xC00, `pm`=0, `set_mode`=00, `sec_tick`=0. The first `sec_tick` occurs 10 cycles after reset release.
2. **Rollover:** preload by button to 11:59 AM, run 60 ticks → `time_bus`=0xC00, `pm`=1. Run a further 60×60 ticks → `time_bus`=0x100, `pm`=1.
3. **Debounce:**
   - 3-cycle `btnC` glitch → `set_mode` stays 00.
   - 10-cycle press → `set_mode`=01 exactly once, 7 cycles after the raw edge.
   - Holding `btnC` for 50 cycles → still a single transition.
4. **Set hour:** in SET_HR, 13 `btnR` presses from 12 AM → hour 1 and `pm`=1. One toggle occurred at 11→12; no others.
5. **Set minutes:** in SET_MIN from :58, 3 presses → `time_bus`[7:0]=0x01 and hour unchanged. Ticks during SET_MIN leave `time_bus` unchanged.
6. **Exit and simultaneous events:**
   - Exit SET_MIN → next minute advance occurs exactly 60×10 cycles after exit.
   - `btnC`+`btnR` accepted in the same cycle in SET_HR → mode becomes 10, hour unchanged.
   - `btnU` asserted mid-debounce → returns to the scenario 1 values and no pulse follows.

Source files
------------

// File: rtl/clock_ctrl.sv
// rtl/clock_ctrl.sv - 12-hour timekeeper with 1 Hz tick and debounced mode/increment buttons
module clock_ctrl #(
  parameter int sys_freq  = 100000000,
  parameter int db_cycles = 1000000
) (
  input  logic        clk,
  input  logic        btnU,
  input  logic        btnC,
  input  logic        btnR,
  output logic [11:0] time_bus,
  output logic        pm,
  output logic [1:0]  set_mode,
  output logic        sec_tick
);

  localparam int TW = (sys_freq > 1) ? $clog2(sys_freq) : 1;
  localparam int DW = (db_cycles > 1) ? $clog2(db_cycles + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(sys_freq - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(db_cycles - 1);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } mode_t;

  // index 0 is the mode button, index 1 the increment button
  logic [1:0]    w_raw;
  logic [1:0]    r_meta;
  logic [1:0]    r_sync;
  logic [1:0]    r_level;
  logic [1:0]    r_level_d;
  logic [DW-1:0] r_db_cnt [2];
  logic [1:0]    w_pulse;
  logic          w_c_pulse;
  logic          w_r_pulse;

  mode_t         r_mode;
  mode_t         w_mode_next;
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  logic          w_exit;

  logic [3:0]    r_hour;
  logic [3:0]    r_tenmin;
  logic [3:0]    r_min;
  logic [5:0]    r_sec;
  logic          r_pm;
  logic [3:0]    w_hour_n;
  logic [3:0]    w_ten_n;
  logic [3:0]    w_min_n;
  logic [5:0]    w_sec_n;
  logic          w_pm_n;
  logic          w_min_adv;
  logic          w_hour_adv;

  assign w_raw     = {btnR, btnC};
  assign w_pulse   = r_level & ~r_level_d;
  assign w_c_pulse = w_pulse[0];
  assign w_r_pulse = w_pulse[1];

  always_ff @(posedge clk) begin
    if (btnU) begin
      r_meta    <= '0;
      r_sync    <= '0;
      r_level   <= '0;
      r_level_d <= '0;
      for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
    end else begin
      r_meta    <= w_raw;
      r_sync    <= r_meta;
      r_level_d <= r_level;
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_level[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db_cnt[i] <= '0;
          r_level[i]  <= ~r_level[i];
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign w_tick   = (r_tick_cnt == TICK_LAST);
  assign w_exit   = (r_mode == SET_MIN) && w_c_pulse;
  assign sec_tick = w_tick;

  always_comb begin
    w_mode_next = r_mode;
    if (w_c_pulse) begin
      case (r_mode)
        RUN:     w_mode_next = SET_HR;
        SET_HR:  w_mode_next = SET_MIN;
        default: w_mode_next = RUN;
      endcase
    end
  end

  always_comb begin
    w_sec_n    = r_sec;
    w_min_n    = r_min;
    w_ten_n    = r_tenmin;
    w_hour_n   = r_hour;
    w_pm_n     = r_pm;
    w_min_adv  = 1'b0;
    w_hour_adv = 1'b0;
    case (r_mode)
      RUN: begin
        if (w_tick) begin
          if (r_sec == 6'd59) begin
            w_sec_n   = '0;
            w_min_adv = 1'b1;
          end else begin
            w_sec_n = r_sec + 6'd1;
          end
        end
      end
      SET_HR:  w_hour_adv = w_r_pulse && !w_c_pulse;
      SET_MIN: begin
        if (w_exit) w_sec_n = '0;
        else if (w_r_pulse) w_min_adv = 1'b1;
      end
      default: ;
    endcase
    // SET_MIN wraps 59->00 without carrying into the hour
    if (w_min_adv) begin
      if (r_min == 4'd9) begin
        w_min_n = 4'd0;
        if (r_tenmin == 4'd5) begin
          w_ten_n    = 4'd0;
          w_hour_adv = (r_mode == RUN);
        end else begin
          w_ten_n = r_tenmin + 4'd1;
        end
      end else begin
        w_min_n = r_min + 4'd1;
      end
    end
    if (w_hour_adv) begin
      if (r_hour == 4'd12) begin
        w_hour_n = 4'd1;
      end else begin
        w_hour_n = r_hour + 4'd1;
        if (r_hour == 4'd11) w_pm_n = ~r_pm;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (btnU) begin
      r_mode     <= RUN;
      r_tick_cnt <= '0;
      r_hour     <= 4'd12;
      r_tenmin   <= 4'd0;
      r_min      <= 4'd0;
      r_sec      <= 6'd0;
      r_pm       <= 1'b0;
    end else begin
      r_mode     <= w_mode_next;
      r_tick_cnt <= (w_exit || w_tick) ? '0 : r_tick_cnt + TW'(1);
      r_hour     <= w_hour_n;
      r_tenmin   <= w_ten_n;
      r_min      <= w_min_n;
      r_sec      <= w_sec_n;
      r_pm       <= w_pm_n;
    end
  end

  assign time_bus = {r_hour, r_tenmin, r_min};
  assign pm       = r_pm;
  assign set_mode = r_mode;

endmodule

// File: tb/tb_clock_ctrl.sv
// tb/tb_clock_ctrl.sv - table, directed and randomized checks of clock_ctrl against a minutes-of-day model
module tb_clock_ctrl;

  localparam int SYS_FREQ = 10;
  localparam int DB       = 4;
  localparam int LAT      = 2 + DB + 1;

  logic        clk = 1'b0;
  logic        btnU;
  logic        btnC;
  logic        btnR;
  logic [11:0] time_bus;
  logic        pm;
  logic [1:0]  set_mode;
  logic        sec_tick;

  clock_ctrl #(.sys_freq(SYS_FREQ), .db_cycles(DB)) dut (
    .clk      (clk),
    .btnU     (btnU),
    .btnC     (btnC),
    .btnR     (btnR),
    .time_bus (time_bus),
    .pm       (pm),
    .set_mode (set_mode),
    .sec_tick (sec_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        c;
    logic        r;
    int          count;
    logic [11:0] bus;
    logic        pm;
    logic [1:0]  mode;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // model: m_t is minutes since 12:00 AM (0..1439)
  int m_t, m_sec, m_mode, m_anchor;
  int c_q[$];
  int r_q[$];
  int last_c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] exp_bus();
    int h;
    h = (m_t / 60) % 12;
    if (h == 0) h = 12;
    return {h[3:0], 4'((m_t % 60) / 10), 4'(m_t % 10)};
  endfunction

  task automatic model_edge();
    bit c, r, tick;
    if (btnU) begin
      m_t = 0; m_sec = 0; m_mode = 0; m_anchor = cyc;
      c_q.delete();
      r_q.delete();
      return;
    end
    c = (c_q.size() > 0) && (c_q[0] == cyc);
    if (c) void'(c_q.pop_front());
    r = (r_q.size() > 0) && (r_q[0] == cyc);
    if (r) void'(r_q.pop_front());
    tick = (cyc > m_anchor) && (((cyc - m_anchor) % SYS_FREQ) == 0);
    case (m_mode)
      0: begin
        if (tick) begin
          m_sec++;
          if (m_sec == 60) begin
            m_sec = 0;
            m_t = (m_t + 1) % 1440;
          end
        end
        if (c) m_mode = 1;
      end
      1: begin
        if (c) m_mode = 2;
        else if (r) m_t = (m_t + 60) % 1440;
      end
      default: begin
        if (c) begin
          m_mode = 0; m_sec = 0; m_anchor = cyc;
        end else if (r) begin
          m_t = m_t - (m_t % 60) + ((m_t % 60) + 1) % 60;
        end
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk("state{bus,pm,mode,tick}", {time_bus, pm, set_mode, sec_tick},
        {exp_bus(), 1'(m_t >= 720), 2'(m_mode), 1'(((cyc + 1 - m_anchor) % SYS_FREQ) == 0)});
  endtask

  task automatic press(input logic c, input logic r, input int hold, input int gap);
    btnC = c;
    btnR = r;
    if (hold >= DB) begin
      if (c) begin
        c_q.push_back(cyc + LAT);
        last_c = cyc + LAT;
      end
      if (r) r_q.push_back(cyc + LAT);
    end
    repeat (hold) step();
    btnC = 1'b0;
    btnR = 1'b0;
    repeat (gap) step();
  endtask

  task automatic do_reset();
    btnU = 1'b1;
    btnC = 1'b0;
    btnR = 1'b0;
    step();
    btnU = 1'b0;
  endtask

  initial begin
    vec_t tab [14];
    int sel, hold, gap;
    btnU = 1'b1;
    btnC = 1'b0;
    btnR = 1'b0;
    tab[0]  = '{1'b1, 1'b0,  1, 12'hC00, 1'b0, 2'd1};
    tab[1]  = '{1'b0, 1'b1, 11, 12'hB00, 1'b0, 2'd1};
    tab[2]  = '{1'b0, 1'b1,  1, 12'hC00, 1'b1, 2'd1};
    tab[3]  = '{1'b0, 1'b1,  1, 12'h100, 1'b1, 2'd1};
    tab[4]  = '{1'b1, 1'b0,  1, 12'h100, 1'b1, 2'd2};
    tab[5]  = '{1'b0, 1'b1, 58, 12'h158, 1'b1, 2'd2};
    tab[6]  = '{1'b0, 1'b1,  3, 12'h101, 1'b1, 2'd2};
    tab[7]  = '{1'b0, 1'b0, 25, 12'h101, 1'b1, 2'd2};
    tab[8]  = '{1'b1, 1'b0,  1, 12'h101, 1'b1, 2'd0};
    tab[9]  = '{1'b0, 1'b1,  2, 12'h101, 1'b1, 2'd0};
    tab[10] = '{1'b1, 1'b0,  1, 12'h101, 1'b1, 2'd1};
    tab[11] = '{1'b1, 1'b1,  1, 12'h101, 1'b1, 2'd2};
    tab[12] = '{1'b0, 1'b1,  1, 12'h102, 1'b1, 2'd2};
    tab[13] = '{1'b1, 1'b0,  1, 12'h102, 1'b1, 2'd0};

    do_reset();
    chk("rst_bus", time_bus, 12'hC00);
    chk("rst_pm", pm, 0);
    chk("rst_mode", set_mode, 0);
    chk("rst_tick", sec_tick, 0);
    for (int k = 1; k <= SYS_FREQ - 1; k++) begin
      step();
      chk("first_tick", sec_tick, (k == SYS_FREQ - 1) ? 1 : 0);
    end

    press(1'b1, 1'b0, 3, 12);
    chk("glitch_mode", set_mode, 0);
    c_q.push_back(cyc + LAT);
    btnC = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      step();
      chk("press_latency_mode", set_mode, (k == LAT) ? 1 : 0);
    end
    repeat (3) step();
    btnC = 1'b0;
    repeat (12) step();
    chk("press10_mode", set_mode, 1);
    press(1'b1, 1'b0, 50, 12);
    chk("hold50_mode", set_mode, 2);

    do_reset();
    foreach (tab[i]) begin
      if (!tab[i].c && !tab[i].r) repeat (tab[i].count) step();
      else repeat (tab[i].count) press(tab[i].c, tab[i].r, 5, 8);
      chk($sformatf("vec%0d_bus", i), time_bus, tab[i].bus);
      chk($sformatf("vec%0d_pm", i), pm, tab[i].pm);
      chk($sformatf("vec%0d_mode", i), set_mode, tab[i].mode);
    end

    do_reset();
    press(1'b1, 1'b0, 5, 8);
    repeat (11) press(1'b0, 1'b1, 5, 8);
    press(1'b1, 1'b0, 5, 8);
    repeat (59) press(1'b0, 1'b1, 5, 8);
    chk("preload_bus", time_bus, 12'hB59);
    press(1'b1, 1'b0, 5, 8);
    while (cyc < last_c + 60 * SYS_FREQ - 1) step();
    chk("exit_599_bus", time_bus, 12'hB59);
    step();
    chk("exit_600_bus", time_bus, 12'hC00);
    chk("exit_600_pm", pm, 1);
    while (cyc < last_c + 61 * 60 * SYS_FREQ - 1) step();
    chk("hour_roll_before", time_bus, 12'hC59);
    step();
    chk("hour_roll_bus", time_bus, 12'h100);
    chk("hour_roll_pm", pm, 1);

    do_reset();
    for (int it = 0; it < 60; it++) begin
      sel  = $urandom_range(0, 9);
      hold = $urandom_range(DB, DB + 6);
      gap  = $urandom_range(6, 15);
      case (sel)
        0, 1:    press(1'b1, 1'b0, hold, gap);
        2, 3, 4: press(1'b0, 1'b1, hold, gap);
        5:       press(1'b1, 1'b1, hold, gap);
        6:       press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, DB - 1), gap);
        default: repeat ($urandom_range(1, 400)) step();
      endcase
    end

    press(1'b1, 1'b0, 5, 8);
    btnC = 1'b1;
    repeat (4) step();
    btnU = 1'b1;
    btnC = 1'b0;
    step();
    btnU = 1'b0;
    chk("midrst_bus", time_bus, 12'hC00);
    chk("midrst_pm", pm, 0);
    chk("midrst_mode", set_mode, 0);
    chk("midrst_tick", sec_tick, 0);
    repeat (15) step();
    chk("midrst_no_pulse", set_mode, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
